// File: rtl/audio_i2s_transmitter_pkg.sv
// Shared audio types and I2S frame geometry for the transmitter and the FIFO controller.
package audio_pkg;

  localparam int SLOT_BITS   = 32;
  localparam int FRAME_TICKS = 256;
  localparam int PHASE_W     = 8;

  typedef struct packed {
    logic [15:0] left;
    logic [15:0] right;
  } stereo_sample_t;

endpackage

// File: rtl/audio_i2s_transmitter_if.sv
// Sample handshake with the FIFO controller plus the I2S pins.
// master = transmitter side, slave = controller/receiver side.
interface audio_i2s_transmitter_if;

  logic [15:0] i_sample_left;
  logic [15:0] i_sample_right;
  logic        o_sample_clock;
  logic        o_i2s_mclk;
  logic        o_i2s_bclk;
  logic        o_i2s_lrck;
  logic        o_i2s_sdata;

  modport master (
    input  i_sample_left, i_sample_right,
    output o_sample_clock, o_i2s_mclk, o_i2s_bclk, o_i2s_lrck, o_i2s_sdata
  );

  modport slave (
    output i_sample_left, i_sample_right,
    input  o_sample_clock, o_i2s_mclk, o_i2s_bclk, o_i2s_lrck, o_i2s_sdata
  );

endinterface

// File: rtl/audio_i2s_transmitter_tick_divider.sv
// Prescaler producing one 256*fs tick every max(i_rate_div,1) clocks.
// The wrap compare is ">=" so shrinking the divisor below the running count
// forces an immediate wrap instead of running out to 2^32.
module audio_tick_divider (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_enable,
  input  logic [31:0] i_rate_div,
  output logic        tick
);

  logic [31:0] pc;
  logic [31:0] div_m1;

  // Clamp 0 to 1 before subtracting so D-1 never underflows.
  always_comb begin
    div_m1 = (i_rate_div == 32'd0) ? 32'd0 : (i_rate_div - 32'd1);
  end

  assign tick = i_enable && (pc >= div_m1);

  // Count 0..D-1, wrap on tick, park at 0 while held or disabled.
  always_ff @(posedge i_clock) begin
    if (i_reset || !i_enable) begin
      pc <= 32'd0;
    end else if (tick) begin
      pc <= 32'd0;
    end else begin
      pc <= pc + 32'd1;
    end
  end

endmodule

// File: rtl/audio_i2s_transmitter.sv
// I2S transmitter: phase counter driven by the tick divider, per-frame sample
// shadowing with a toggle handshake, and registered MCLK/BCLK/LRCK/SDATA.
module audio_i2s_transmitter
  import audio_pkg::*;
#(
  parameter int SAMPLE_BITS = 16
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_enable,
  input  logic [31:0]             i_rate_div,
  audio_i2s_transmitter_if.master bus
);

  logic               tick;
  logic [PHASE_W-1:0] phase;
  stereo_sample_t     shadow;
  logic [15:0]        word;
  logic [4:0]         bit_k;
  logic [3:0]         bit_idx;
  logic               bit_sel;
  logic               sample_clock_q;
  logic               mclk_q, bclk_q, lrck_q, sdata_q;

  audio_tick_divider u_div (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_enable   (i_enable),
    .i_rate_div (i_rate_div),
    .tick       (tick)
  );

  // Slot bit k: bit 0 is the one-BCLK I2S delay, then MSB-first data, then zero padding.
  always_comb begin
    bit_k   = phase[6:2];
    word    = phase[7] ? shadow.right : shadow.left;
    bit_idx = 4'(SAMPLE_BITS - int'(bit_k));
    bit_sel = 1'b0;
    if (bit_k != 5'd0 && int'(bit_k) <= SAMPLE_BITS) begin
      bit_sel = word[bit_idx];
    end
  end

  // Phase advance, frame-start latch/handshake, and output registers (one cycle behind phase).
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      phase          <= '0;
      shadow         <= '0;
      sample_clock_q <= 1'b0;
      mclk_q         <= 1'b0;
      bclk_q         <= 1'b0;
      lrck_q         <= 1'b0;
      sdata_q        <= 1'b0;
    end else if (!i_enable) begin
      phase   <= '0;
      shadow  <= '0;
      mclk_q  <= 1'b0;
      bclk_q  <= 1'b0;
      lrck_q  <= 1'b0;
      sdata_q <= 1'b0;
    end else begin
      if (tick) begin
        phase <= phase + 8'd1;
        if (phase == 8'(FRAME_TICKS - 1)) begin
          shadow         <= '{left: bus.i_sample_left, right: bus.i_sample_right};
          sample_clock_q <= ~sample_clock_q;
        end
      end
      mclk_q  <= phase[0];
      bclk_q  <= phase[1];
      lrck_q  <= phase[7];
      sdata_q <= bit_sel;
    end
  end

  assign bus.o_sample_clock = sample_clock_q;
  assign bus.o_i2s_mclk     = mclk_q;
  assign bus.o_i2s_bclk     = bclk_q;
  assign bus.o_i2s_lrck     = lrck_q;
  assign bus.o_i2s_sdata    = sdata_q;

endmodule

// File: tb/tb_audio_i2s_transmitter.sv
// Bench for audio_i2s_transmitter: clock-rate measurements, an I2S receiver
// that recovers words from the pins, and a FIFO model for the toggle handshake.
module tb_audio_i2s_transmitter;

  logic        i_clock;
  logic        i_reset;
  logic        i_enable;
  logic [31:0] i_rate_div;

  audio_i2s_transmitter_if bus_if ();

  audio_i2s_transmitter dut (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_enable   (i_enable),
    .i_rate_div (i_rate_div),
    .bus        (bus_if)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  int n_tests;
  int n_fail;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic get_sig(input int sel);
    case (sel)
      0: return bus_if.o_i2s_mclk;
      1: return bus_if.o_i2s_bclk;
      2: return bus_if.o_i2s_lrck;
      3: return bus_if.o_i2s_sdata;
      default: return bus_if.o_sample_clock;
    endcase
  endfunction

  // Cycles until the selected output changes (rise_only: 0->1 only); -1 on timeout.
  task automatic wait_edge(input int sel, input bit rise_only, input int bound, output int cyc);
    logic prev, cur;
    prev = get_sig(sel);
    cyc  = -1;
    for (int n = 1; n <= bound; n++) begin
      @(posedge i_clock); #1;
      cur = get_sig(sel);
      if ((rise_only && !prev && cur) || (!rise_only && (cur !== prev))) begin
        cyc = n;
        break;
      end
      prev = cur;
    end
  endtask

  task automatic measure_period(input int sel, input int bound, output int per);
    int c;
    per = -1;
    wait_edge(sel, 1'b1, bound, c);
    if (c > 0) wait_edge(sel, 1'b1, bound, per);
  endtask

  // Reset held 3 cycles; released 1 time unit after the third edge.
  task automatic apply_reset();
    i_reset = 1'b1;
    repeat (3) @(posedge i_clock);
    #1;
    chk("rst_mclk",  32'(bus_if.o_i2s_mclk),     32'd0);
    chk("rst_bclk",  32'(bus_if.o_i2s_bclk),     32'd0);
    chk("rst_lrck",  32'(bus_if.o_i2s_lrck),     32'd0);
    chk("rst_sdata", 32'(bus_if.o_i2s_sdata),    32'd0);
    chk("rst_sclk",  32'(bus_if.o_sample_clock), 32'd0);
    i_reset = 1'b0;
  endtask

  // I2S receiver and FIFO model state
  logic [15:0] rx_l[$];
  logic [15:0] rx_r[$];
  logic [15:0] rx_sh;
  int          rx_bad, rx_cnt, tog_since;
  logic        rx_prev_b, rx_last_lr, rx_prev_lr, prev_sc;
  bit          fifo_mode;
  logic [15:0] fifo_l[$];
  logic [15:0] fifo_r[$];

  task automatic rx_clear();
    rx_l.delete(); rx_r.delete();
    rx_sh = '0; rx_bad = 0; rx_cnt = 0; tog_since = 0;
    rx_prev_b = 1'b0; rx_last_lr = 1'b0; rx_prev_lr = 1'b0;
    prev_sc = bus_if.o_sample_clock;
  endtask

  task automatic rx_run(input int ncyc);
    logic b, lr, sd, sc;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge i_clock); #1;
      b = bus_if.o_i2s_bclk; lr = bus_if.o_i2s_lrck;
      sd = bus_if.o_i2s_sdata; sc = bus_if.o_sample_clock;
      if (fifo_mode && sc !== prev_sc) begin
        tog_since++;
        if (fifo_l.size() > 0) begin
          bus_if.i_sample_left  = fifo_l.pop_front();
          bus_if.i_sample_right = fifo_r.pop_front();
        end
      end
      prev_sc = sc;
      if (fifo_mode && rx_prev_lr && !lr) begin
        chk("toggles_per_frame", 32'(tog_since), 32'd1);
        tog_since = 0;
      end
      rx_prev_lr = lr;
      if (!rx_prev_b && b) begin
        if (lr !== rx_last_lr) begin
          rx_cnt = 0;
          rx_last_lr = lr;
        end
        if (rx_cnt >= 1 && rx_cnt <= 16) rx_sh = {rx_sh[14:0], sd};
        else if (sd !== 1'b0) rx_bad++;
        if (rx_cnt == 16) begin
          if (lr) rx_r.push_back(rx_sh);
          else    rx_l.push_back(rx_sh);
        end
        rx_cnt++;
      end
      rx_prev_b = b;
    end
  endtask

  function automatic logic [15:0] q_at(input logic [15:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 16'hxxxx;
  endfunction

  task automatic serial_test(input logic [15:0] l, input logic [15:0] r);
    i_enable = 1'b1; i_rate_div = 32'd2; fifo_mode = 1'b0;
    bus_if.i_sample_left = l; bus_if.i_sample_right = r;
    apply_reset();
    rx_clear();
    rx_run(2 * 512 + 300);
    chk("ser_l0", 32'(q_at(rx_l, 0)), 32'd0);
    chk("ser_r0", 32'(q_at(rx_r, 0)), 32'd0);
    chk("ser_l1", 32'(q_at(rx_l, 1)), 32'(l));
    chk("ser_r1", 32'(q_at(rx_r, 1)), 32'(r));
    chk("ser_zero_bits", 32'(rx_bad), 32'd0);
  endtask

  initial begin
    int d, c, per;
    logic [15:0] s_l[4];
    logic [15:0] s_r[4];
    n_tests = 0; n_fail = 0;
    i_reset = 1'b1; i_enable = 1'b1; i_rate_div = 32'd5;
    bus_if.i_sample_left = '0; bus_if.i_sample_right = '0;
    fifo_mode = 1'b0;

    // Reset and first-tick latency: tick on the D-th edge, MCLK registered one edge later
    d = $urandom_range(3, 20);
    i_rate_div = 32'(d);
    apply_reset();
    wait_edge(0, 1'b1, 200, c);
    chk("first_tick_latency", 32'(c), 32'(d + 1));

    // Divider periods
    apply_reset();
    i_rate_div = 32'd17;
    measure_period(2, 20000, per); chk("lrck_period_d17", 32'(per), 32'd4352);
    measure_period(1, 500, per);   chk("bclk_period_d17", 32'(per), 32'd68);
    measure_period(0, 500, per);   chk("mclk_period_d17", 32'(per), 32'd34);
    apply_reset();
    i_rate_div = 32'd0;
    measure_period(2, 2000, per);  chk("lrck_period_d0", 32'(per), 32'd256);
    measure_period(1, 100, per);   chk("bclk_period_d0", 32'(per), 32'd4);
    d = $urandom_range(2, 6);
    apply_reset();
    i_rate_div = 32'(d);
    measure_period(2, 8000, per);  chk("lrck_period_rand", 32'(per), 32'(256 * d));
    measure_period(1, 200, per);   chk("bclk_period_rand", 32'(per), 32'(4 * d));

    // Serialisation: fixed pattern, then random words
    serial_test(16'hA5C3, 16'h0001);
    serial_test(16'($urandom), 16'($urandom));

    // Handshake with a 4-deep FIFO model; last sample replays once empty
    for (int i = 0; i < 4; i++) begin
      s_l[i] = 16'($urandom);
      s_r[i] = 16'($urandom);
    end
    fifo_l.delete(); fifo_r.delete();
    for (int i = 1; i < 4; i++) begin
      fifo_l.push_back(s_l[i]);
      fifo_r.push_back(s_r[i]);
    end
    bus_if.i_sample_left = s_l[0]; bus_if.i_sample_right = s_r[0];
    i_rate_div = 32'd1; fifo_mode = 1'b1;
    apply_reset();
    rx_clear();
    rx_run(7 * 256 + 60);
    for (int f = 0; f < 7; f++) begin
      int si;
      si = (f - 1 > 3) ? 3 : f - 1;
      chk($sformatf("fifo_l%0d", f), 32'(q_at(rx_l, f)), (f == 0) ? 32'd0 : 32'(s_l[si]));
      chk($sformatf("fifo_r%0d", f), 32'(q_at(rx_r, f)), (f == 0) ? 32'd0 : 32'(s_r[si]));
    end
    chk("fifo_zero_bits", 32'(rx_bad), 32'd0);
    fifo_mode = 1'b0;

    // Rate change mid-count: D=100, drop to 10 while the count is at 50
    i_rate_div = 32'd100;
    apply_reset();
    repeat (50) @(posedge i_clock);
    #1;
    i_rate_div = 32'd10;
    wait_edge(0, 1'b0, 10, c);
    chk("ratechg_first_tick", 32'(c), 32'd2);
    chk("ratechg_bclk_1", 32'(bus_if.o_i2s_bclk), 32'd0);
    for (int n = 2; n <= 8; n++) begin
      wait_edge(0, 1'b0, 50, c);
      chk($sformatf("ratechg_period_%0d", n), 32'(c), 32'd10);
      chk($sformatf("ratechg_bclk_%0d", n), 32'(bus_if.o_i2s_bclk), 32'((n >> 1) & 1));
    end

    // Enable drop at phase 130 of the second frame, then restart from phase 0
    i_rate_div = 32'd1;
    apply_reset();
    repeat (386) @(posedge i_clock);
    #1;
    chk("pre_drop_lrck", 32'(bus_if.o_i2s_lrck), 32'd1);
    chk("pre_drop_sclk", 32'(bus_if.o_sample_clock), 32'd1);
    i_enable = 1'b0;
    @(posedge i_clock); #1;
    chk("drop_mclk",  32'(bus_if.o_i2s_mclk),  32'd0);
    chk("drop_bclk",  32'(bus_if.o_i2s_bclk),  32'd0);
    chk("drop_lrck",  32'(bus_if.o_i2s_lrck),  32'd0);
    chk("drop_sdata", 32'(bus_if.o_i2s_sdata), 32'd0);
    repeat (4) @(posedge i_clock);
    #1;
    chk("drop_sclk_hold", 32'(bus_if.o_sample_clock), 32'd1);
    chk("drop_mclk_idle", 32'(bus_if.o_i2s_mclk), 32'd0);
    i_enable = 1'b1;
    wait_edge(2, 1'b1, 400, c);
    chk("reenable_left_first", 32'(c), 32'd129);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
